// File: rtl/keccak_ctrl.sv
`default_nettype none
// ============================================================================
// keccak_ctrl : owns the 50-word Keccak state buffer, streams it through the
//               permutation core and back, and reports completion on the bus.
// Revision    : 1.0
// ============================================================================
module keccak_ctrl #(
  parameter int NumWords = 50,
  parameter int IdxW     = $clog2(NumWords)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ctrl_start_i,
  input  logic            ctrl_clear_i,
  input  logic            ctrl_irq_en_i,
  output logic            status_busy_o,
  output logic            status_done_o,
  output logic            irq_o,
  input  logic            bus_req_i,
  input  logic            bus_we_i,
  input  logic [IdxW-1:0] bus_addr_i,
  input  logic [31:0]     bus_wdata_i,
  output logic            bus_gnt_o,
  output logic            bus_rvalid_o,
  output logic [31:0]     bus_rdata_o,
  output logic [31:0]     core_din_o,
  output logic            core_din_valid_o,
  input  logic            core_din_ready_i,
  output logic            core_start_o,
  input  logic            core_done_i,
  input  logic [31:0]     core_dout_i,
  input  logic            core_dout_valid_i,
  output logic            core_dout_ready_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(NumWords - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;

  // State buffer is deliberately left out of reset.
  logic [31:0]     mem_q [NumWords];

  logic            mem_we;
  logic [IdxW-1:0] mem_waddr;
  logic [31:0]     mem_wdata;

  logic            bus_addr_ok;
  logic            bus_gnt;
  logic            last_idx;
  logic            din_fire;
  logic            dout_fire;

  always_comb begin
    bus_addr_ok = (bus_addr_i <= LAST_IDX);
    bus_gnt     = (state_q == ST_IDLE) && bus_req_i;
    last_idx    = (idx_q == LAST_IDX);
    din_fire    = (state_q == ST_LOAD) && core_din_ready_i;
    dout_fire   = (state_q == ST_UNLOAD) && core_dout_valid_i;
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    mem_we            = 1'b0;
    mem_waddr         = bus_addr_i;
    mem_wdata         = bus_wdata_i;
    core_din_valid_o  = 1'b0;
    core_din_o        = '0;
    core_start_o      = 1'b0;
    core_dout_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_gnt && bus_we_i && bus_addr_ok) begin
          mem_we = 1'b1;
        end
        if (ctrl_start_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end

      ST_LOAD: begin
        core_din_valid_o = 1'b1;
        core_din_o       = mem_q[idx_q];
        if (din_fire) begin
          if (last_idx) begin
            state_d = ST_START;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_START: begin
        core_start_o = 1'b1;
        state_d      = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_done_i) begin
          state_d = ST_UNLOAD;
        end
      end

      ST_UNLOAD: begin
        core_dout_ready_o = 1'b1;
        if (dout_fire) begin
          mem_we    = 1'b1;
          mem_waddr = idx_q;
          mem_wdata = core_dout_i;
          if (last_idx) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Setting in DONE takes priority over a simultaneous clear.
  always_comb begin
    done_d   = (state_q == ST_DONE) || (done_q && !ctrl_clear_i);
    rvalid_d = bus_gnt;
    rdata_d  = '0;
    if (bus_gnt && !bus_we_i && bus_addr_ok) begin
      rdata_d = mem_q[bus_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign status_busy_o = (state_q != ST_IDLE);
  assign status_done_o = done_q;
  assign irq_o         = done_q && ctrl_irq_en_i;
  assign bus_gnt_o     = bus_gnt;
  assign bus_rvalid_o  = rvalid_q;
  assign bus_rdata_o   = rdata_q;

endmodule
`default_nettype wire
